nibble_adder_arbiter: RTL and testbench
=======================================

Name: nibble_adder_arbiter

Overview:
Shares one registered nibble adder among N_REQ requesters using round-robin arbitration. Each requester presents two W-bit operands on a valid/ready handshake. The block returns a W+1-bit sum tagged with the requester ID through a one-entry output register that accepts backpressure. It sits between the ui_in-decoding front end and the uo_out driver in the tt_um top level, and replaces the direct per-cycle adder.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 4, operand width in bits
IDW, $clog2(N_REQ) (minimum 1), width of the requester ID; derived, not overridden

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous reset, active low
req_valid  input  N_REQ  per-requester operand-valid
req_a  input  N_REQ*W  operand A; requester i uses bits [i*W +: W]
req_b  input  N_REQ*W  operand B; same packing as req_a
req_ready  output  N_REQ  per-requester grant/accept; one-hot or zero
rsp_valid  output  1  result-register valid
rsp_ready  input  1  downstream accept
rsp_id  output  IDW  index of the requester that owns rsp_sum
rsp_sum  output  W+1  req_a + req_b, zero-extended; MSB is the carry
carry_cnt  output  8  saturating count of accepted results with carry = 1

Behaviour:
- Reset (rst_n low, asynchronous, takes effect at once, mid-transfer included):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, carry_cnt=0.
  - Internal round-robin pointer rr_ptr=0.
  - req_ready is combinational and is all-zero while rsp_valid=0 and no req_valid is high.
- Capacity: can_accept = !rsp_valid || rsp_ready (the register is empty or is draining this cycle).
- Arbitration (combinational):
  - If can_accept is high and any req_valid is high, g is the first i with req_valid[i]=1, searching circularly from rr_ptr upward and wrapping from N_REQ-1 to 0.
  - req_ready[g]=1; every other bit is 0.
  - If can_accept is low, req_ready is all-zero.
- Handshake rules:
  - A transfer occurs when req_valid[g] and req_ready[g] are both high at the clock edge.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
  - A requester holds its operands stable while valid is high and not yet accepted.
- On a transfer at edge t:
  - At edge t: rsp_valid<=1, rsp_id<=g, rsp_sum<={1'b0,a_g}+{1'b0,b_g}.
  - At edge t: rr_ptr<=(g==N_REQ-1)?0:g+1.
  - Latency is 1 cycle, request accept to rsp_valid.
- Output register:
  - When rsp_valid=1 and rsp_ready=1 with no new transfer, rsp_valid<=0. rsp_id and rsp_sum keep their last values.
  - When rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_id and rsp_sum hold unchanged.
  - A drain and a new transfer in the same cycle load the new result with no bubble. Throughput is 1 result per cycle while rsp_ready=1.
- rr_ptr does not change in cycles without a transfer.
- carry_cnt:
  - Increments by 1 on each output handshake (rsp_valid and rsp_ready) where rsp_sum[W]=1.
  - Saturates at 255 and never wraps.
- Arithmetic: unsigned. The maximum sum 2*(2^W-1) fits in W+1 bits, so there is no overflow.
- Idle: with no req_valid, req_ready=0 and the state is unchanged apart from the drain.

Test Plan:
- Assert rst_n=0 asynchronously, between edges, while rsp_valid=1, rsp_sum=5'h0C, carry_cnt=3 -> all outputs 0 immediately; rr_ptr=0 (next grant goes to requester 0 when all requesters are valid).
- Requester 1 only: a=7, b=9, rsp_ready=1 -> req_ready=4'b0010 in the same cycle; next cycle rsp_valid=1, rsp_id=1, rsp_sum=5'b10000; carry_cnt=1 after the handshake.
- All 4 requesters valid continuously, rsp_ready=1, a_i=i, b_i=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_sum 1,2,3,4,1 with no bubbles.
- rsp_ready=0 while rsp_valid=1 and requesters pending -> req_ready=0 and rsp_* stable for 5 cycles; raise rsp_ready -> next grant accepted in that same cycle, new result on the next edge.
- After a grant to requester 1 (rr_ptr=2), only requesters 0 and 3 valid -> grant 3 first, then 0; requester 3 does not win twice in a row.
- Send 300 results with a=15, b=15 (sum 5'h1E) -> carry_cnt reaches 255 and stays at 255.

Source files
------------

// File: rtl/nibble_adder_arbiter.sv
// Round-robin shared nibble adder: N_REQ requesters feed one registered W-bit adder.
// Latency: 1 cycle from request accept to rsp_valid; 1 result/cycle while rsp_ready=1.
// Backpressure: one-entry output register; req_ready drops to zero while it is full and not draining.
//
// Ports:
//   clk, rst_n            - clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   - per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b          - packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready   - result handshake
//   rsp_id, rsp_sum       - owner of the result and the W+1-bit sum (MSB = carry)
//   carry_cnt             - saturating count of delivered results whose carry is set
module nibble_adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W:0]           rsp_sum,
    output logic [7:0]           carry_cnt
);

    logic [IDW-1:0] rr_ptr;
    logic           can_accept;
    logic           found;
    logic [IDW-1:0] grant_id;
    logic           xfer;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;

    // The register can take a new result when empty or when it is being read this cycle.
    assign can_accept = !rsp_valid || rsp_ready;

    // Circular search for the first valid requester starting at rr_ptr.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = IDW'(idx);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
    end

    // req_ready is only raised towards a requester that is already valid, so
    // a grant is always a transfer.
    assign xfer = can_accept && found;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign a_sel = req_a[int'(grant_id)*W +: W];
    assign b_sel = req_b[int'(grant_id)*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                rsp_valid <= 1'b1;
                rsp_id    <= grant_id;
                rsp_sum   <= {1'b0, a_sel} + {1'b0, b_sel};
                rr_ptr    <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end else if (rsp_ready) begin
                // Drain without refill; id/sum keep their last values.
                rsp_valid <= 1'b0;
            end
        end
    end

    // Counts on the output handshake, so a result held under backpressure
    // is counted exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (rsp_valid && rsp_ready && rsp_sum[W] && (carry_cnt != 8'hFF)) begin
            carry_cnt <= carry_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_nibble_adder_arbiter.sv
module tb_nibble_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [4:0]  rsp_sum;
    logic [7:0]  carry_cnt;

    int checks   = 0;
    int failures = 0;

    nibble_adder_arbiter #(.N_REQ(4), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .carry_cnt (carry_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #2;
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, carry_cnt, req_ready} !== 20'd0) begin
            failures++;
            $display("FAIL power_on_reset: got v=%0b id=%0d sum=%h cnt=%0d rdy=%b, want all 0",
                     rsp_valid, rsp_id, rsp_sum, carry_cnt, req_ready);
        end
        rst_n = 1'b1;
        tick();
        // Build up a non-zero state: three carry results delivered, 0x0C held.
        req_valid = 4'b0001;
        req_a[3:0] = 4'd15;
        req_b[3:0] = 4'd15;
        rsp_ready = 1'b1;
        tick(); tick(); tick();
        req_a[3:0] = 4'd6;
        req_b[3:0] = 4'd6;
        tick();
        rsp_ready = 1'b0;
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 5'h0C || carry_cnt !== 8'd3) begin
            failures++;
            $display("FAIL reset_precondition: got v=%0b sum=%h cnt=%0d, want v=1 sum=0c cnt=3",
                     rsp_valid, rsp_sum, carry_cnt);
        end
        // Mid-cycle asynchronous reset.
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, carry_cnt} !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: got v=%0b id=%0d sum=%h cnt=%0d, want all 0",
                     rsp_valid, rsp_id, rsp_sum, carry_cnt);
        end
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset_rr_ptr: got req_ready=%b, want 0001", req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single;
        req_valid   = 4'b0010;
        req_a[7:4]  = 4'd7;
        req_b[7:4]  = 4'd9;
        rsp_ready   = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL single_grant: got req_ready=%b, want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 5'b10000 || carry_cnt !== 8'd0) begin
            failures++;
            $display("FAIL single_result: got v=%0b id=%0d sum=%b cnt=%0d, want v=1 id=1 sum=10000 cnt=0",
                     rsp_valid, rsp_id, rsp_sum, carry_cnt);
        end
        tick();
        checks++;
        if (carry_cnt !== 8'd1 || rsp_valid !== 1'b0 || rsp_sum !== 5'b10000) begin
            failures++;
            $display("FAIL single_drain: got cnt=%0d v=%0b sum=%b, want cnt=1 v=0 sum=10000",
                     carry_cnt, rsp_valid, rsp_sum);
        end
    endtask

    // rr_ptr is 2 here, so requester 3 wins before requester 0.
    task automatic test_skip;
        req_valid    = 4'b1001;
        req_a[3:0]   = 4'd1;
        req_b[3:0]   = 4'd2;
        req_a[15:12] = 4'd3;
        req_b[15:12] = 4'd4;
        rsp_ready    = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL skip_first: got req_ready=%b, want 1000", req_ready);
        end
        tick();
        checks++;
        if (rsp_id !== 2'd3 || rsp_sum !== 5'd7 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL skip_second: got id=%0d sum=%0d rdy=%b, want id=3 sum=7 rdy=0001",
                     rsp_id, rsp_sum, req_ready);
        end
        tick();
        checks++;
        if (rsp_id !== 2'd0 || rsp_sum !== 5'd3 || req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL skip_wrap: got id=%0d sum=%0d rdy=%b, want id=0 sum=3 rdy=1000",
                     rsp_id, rsp_sum, req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_round_robin;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*4 +: 4] = 4'(i);
            req_b[i*4 +: 4] = 4'd1;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                failures++;
                $display("FAIL rr_grant_%0d: got req_ready=%b, want %b", k, req_ready, 4'(1 << (k % 4)));
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_sum !== 5'((k % 4) + 1)) begin
                failures++;
                $display("FAIL rr_result_%0d: got v=%0b id=%0d sum=%0d, want v=1 id=%0d sum=%0d",
                         k, rsp_valid, rsp_id, rsp_sum, k % 4, (k % 4) + 1);
            end
        end
    endtask

    // Entered with rsp = {id 0, sum 1} held, all requesters valid, rr_ptr=1.
    task automatic test_backpressure;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_ready: got req_ready=%b, want 0000", req_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 5'd1) begin
                failures++;
                $display("FAIL bp_hold_%0d: got rdy=%b v=%0b id=%0d sum=%0d, want rdy=0000 v=1 id=0 sum=1",
                         c, req_ready, rsp_valid, rsp_id, rsp_sum);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_release: got req_ready=%b, want 0010", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 5'd2) begin
            failures++;
            $display("FAIL bp_result: got v=%0b id=%0d sum=%0d, want v=1 id=1 sum=2",
                     rsp_valid, rsp_id, rsp_sum);
        end
        req_valid = '0;
        tick();
    endtask

    // After tick k (k>=1) there were k transfers and k-1 handshakes.
    task automatic test_saturate;
        do_reset();
        req_valid    = 4'b0100;
        req_a[11:8]  = 4'd15;
        req_b[11:8]  = 4'd15;
        rsp_ready    = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 255) begin
                checks++;
                if (carry_cnt !== 8'd254 || rsp_sum !== 5'h1E) begin
                    failures++;
                    $display("FAIL sat_254: got cnt=%0d sum=%h, want cnt=254 sum=1e", carry_cnt, rsp_sum);
                end
            end
            if (k == 256) begin
                checks++;
                if (carry_cnt !== 8'd255) begin
                    failures++;
                    $display("FAIL sat_255: got cnt=%0d, want 255", carry_cnt);
                end
            end
        end
        req_valid = '0;
        tick();
        checks++;
        if (carry_cnt !== 8'd255 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL sat_hold: got cnt=%0d v=%0b, want cnt=255 v=0", carry_cnt, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_skip();
        test_round_robin();
        test_backpressure();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
